// File: rtl/sdram_req_arbiter.sv
// Purpose: round-robin arbiter that merges two single-word clients onto the sdram_controller write/read ports.
// Latency: controller request rises two edges after the client is first sampled; client ack follows controller ack by one edge.
// Backpressure: one command in flight; clients hold req until a one-cycle ack; a silent controller is aborted by timeout.
module sdram_req_arbiter #(
   parameter int ADDR_W         = 22,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              iclk,
   input  logic              ireset_n,
   // client A
   input  logic              ia_req,
   input  logic              ia_we,
   input  logic [ADDR_W-1:0] ia_address,
   input  logic [DATA_W-1:0] ia_wdata,
   output logic              oa_ack,
   output logic              oa_err,
   output logic [DATA_W-1:0] oa_rdata,
   // client B
   input  logic              ib_req,
   input  logic              ib_we,
   input  logic [ADDR_W-1:0] ib_address,
   input  logic [DATA_W-1:0] ib_wdata,
   output logic              ob_ack,
   output logic              ob_err,
   output logic [DATA_W-1:0] ob_rdata,
   // controller write port
   output logic              owrite_req,
   output logic [ADDR_W-1:0] owrite_address,
   output logic [DATA_W-1:0] owrite_data,
   input  logic              iwrite_ack,
   // controller read port
   output logic              oread_req,
   output logic [ADDR_W-1:0] oread_address,
   input  logic [DATA_W-1:0] iread_data,
   input  logic              iread_ack,
   // sticky timeout flag
   output logic              oerror
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   // arbitration and command context
   logic              last_b_q;     // 1: B was served most recently
   logic              gnt_b_q;      // client owning the current command
   logic              cmd_we_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;
   logic [CNT_W-1:0]  cnt_q;

   // combinational decisions
   logic              grant_a;
   logic              grant_b;
   logic              ack_match;
   logic              timeout;
   logic              done;

   // next values of the registered outputs
   logic              wr_req_d;
   logic              rd_req_d;
   logic              a_ack_d;
   logic              b_ack_d;
   logic              a_err_d;
   logic              b_err_d;
   logic              err_set;
   logic              rd_load_a;
   logic              rd_load_b;

   // On a tie the client that was not served last wins; a lone requester always wins.
   assign grant_a   = ia_req & (~ib_req | last_b_q);
   assign grant_b   = ib_req & (~ia_req | ~last_b_q);

   // Only the ack of the port we are driving counts; the other port's ack is noise.
   assign ack_match = cmd_we_q ? iwrite_ack : iread_ack;
   assign timeout   = (cnt_q == CNT_MAX);
   assign done      = ack_match | timeout;

   // State register.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> ISSUE on any request, ISSUE -> RELEASE on ack or timeout, RELEASE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (ia_req || ib_req) state_d = S_ISSUE;
         S_ISSUE:   if (done)             state_d = S_RELEASE;
         S_RELEASE:                       state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // Output decode: next values for the registered controller requests and client responses.
   always_comb begin
      wr_req_d  = 1'b0;
      rd_req_d  = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      err_set   = 1'b0;
      rd_load_a = 1'b0;
      rd_load_b = 1'b0;
      if (state_q == S_ISSUE) begin
         // request stays up until the cycle that completes the command
         wr_req_d  = cmd_we_q  & ~done;
         rd_req_d  = ~cmd_we_q & ~done;
         a_ack_d   = done & ~gnt_b_q;
         b_ack_d   = done &  gnt_b_q;
         // an ack on the timeout edge still counts as a clean completion
         err_set   = timeout & ~ack_match;
         a_err_d   = err_set & ~gnt_b_q;
         b_err_d   = err_set &  gnt_b_q;
         rd_load_a = ack_match & ~cmd_we_q & ~gnt_b_q;
         rd_load_b = ack_match & ~cmd_we_q &  gnt_b_q;
      end
   end

   // Command capture at grant, ISSUE cycle counter, and round-robin history.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         last_b_q    <= 1'b1;
         gnt_b_q     <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (grant_a) begin
                  gnt_b_q     <= 1'b0;
                  cmd_we_q    <= ia_we;
                  cmd_addr_q  <= ia_address;
                  cmd_wdata_q <= ia_wdata;
               end else if (grant_b) begin
                  gnt_b_q     <= 1'b1;
                  cmd_we_q    <= ib_we;
                  cmd_addr_q  <= ib_address;
                  cmd_wdata_q <= ib_wdata;
               end
            end
            S_ISSUE: begin
               // saturate so a stuck timeout condition cannot wrap back to zero
               if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            end
            S_RELEASE: begin
               last_b_q <= gnt_b_q;
               cnt_q    <= '0;
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   // Registered outputs: controller requests, client ack/err pulses, read data and sticky error.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         owrite_req <= 1'b0;
         oread_req  <= 1'b0;
         oa_ack     <= 1'b0;
         ob_ack     <= 1'b0;
         oa_err     <= 1'b0;
         ob_err     <= 1'b0;
         oa_rdata   <= '0;
         ob_rdata   <= '0;
         oerror     <= 1'b0;
      end else begin
         owrite_req <= wr_req_d;
         oread_req  <= rd_req_d;
         oa_ack     <= a_ack_d;
         ob_ack     <= b_ack_d;
         oa_err     <= a_err_d;
         ob_err     <= b_err_d;
         if (rd_load_a) oa_rdata <= iread_data;
         if (rd_load_b) ob_rdata <= iread_data;
         if (err_set)   oerror   <= 1'b1;
      end
   end

   // Both controller ports see the same latched address; only the raised request gives it meaning.
   assign owrite_address = cmd_addr_q;
   assign oread_address  = cmd_addr_q;
   assign owrite_data    = cmd_wdata_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Purpose: randomized scoreboard bench for sdram_req_arbiter with a reference order/memory model and a controller model.
// Latency: expectations are queued when commands are generated; the monitor pops them on each client ack.
// Backpressure: clients hold req until ack; the controller model acks in a planned request cycle or never.
module tb_sdram_req_arbiter;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 16;
   localparam int TO     = 8;

   typedef struct {
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                n;      // request-high cycle in which the controller answers
   } cmd_t;

   typedef struct {
      bit                client_b;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                n;
      bit                err;
      logic [DATA_W-1:0] rd_a;
      logic [DATA_W-1:0] rd_b;
      bit                oerr;
   } exp_t;

   logic              iclk = 1'b0;
   logic              ireset_n;
   logic              ia_req, ia_we, ib_req, ib_we;
   logic [ADDR_W-1:0] ia_address, ib_address;
   logic [DATA_W-1:0] ia_wdata, ib_wdata;
   logic              oa_ack, oa_err, ob_ack, ob_err;
   logic [DATA_W-1:0] oa_rdata, ob_rdata;
   logic              owrite_req, oread_req, iwrite_ack, iread_ack, oerror;
   logic [ADDR_W-1:0] owrite_address, oread_address;
   logic [DATA_W-1:0] owrite_data, iread_data;
   logic [127:0]      outs_all;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   cmd_t cmd_a[2];
   cmd_t cmd_b[2];
   logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] ctrl_mem [logic [ADDR_W-1:0]];
   logic [ADDR_W-1:0] pool [4] = '{22'h000003, 22'h3FFFFF, 22'h155555, 22'h0A0A0A};

   // reference model state
   bit                m_last_b;
   bit                m_sticky;
   logic [DATA_W-1:0] m_rd_a, m_rd_b;
   bit                idle_spur_en = 1'b0;

   always #5 iclk = ~iclk;

   assign outs_all = 128'({oa_ack, ob_ack, oa_err, ob_err, oa_rdata, ob_rdata, owrite_req,
                           owrite_address, owrite_data, oread_req, oread_address, oerror});

   sdram_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
      .iclk(iclk), .ireset_n(ireset_n),
      .ia_req(ia_req), .ia_we(ia_we), .ia_address(ia_address), .ia_wdata(ia_wdata),
      .oa_ack(oa_ack), .oa_err(oa_err), .oa_rdata(oa_rdata),
      .ib_req(ib_req), .ib_we(ib_we), .ib_address(ib_address), .ib_wdata(ib_wdata),
      .ob_ack(ob_ack), .ob_err(ob_err), .ob_rdata(ob_rdata),
      .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
      .iwrite_ack(iwrite_ack),
      .oread_req(oread_req), .oread_address(oread_address), .iread_data(iread_data),
      .iread_ack(iread_ack), .oerror(oerror)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.we    = 1'($urandom_range(0, 1));
      c.addr  = pool[$urandom_range(0, 3)];
      c.wdata = DATA_W'($urandom);
      // roughly one in five commands is never answered inside the timeout window
      if ($urandom_range(0, 4) == 0) c.n = int'($urandom_range(TO, TO + 3));
      else                           c.n = int'($urandom_range(1, TO - 1));
      return c;
   endfunction

   task automatic gen_random();
      for (int i = 0; i < 2; i++) begin
         cmd_a[i] = rand_cmd();
         cmd_b[i] = rand_cmd();
      end
   endtask

   task automatic model_reset();
      m_last_b = 1'b1;
      m_sticky = 1'b0;
      m_rd_a   = '0;
      m_rd_b   = '0;
   endtask

   // Request is raised from the second ISSUE cycle, so it is visible for TO-1 cycles
   // before the timeout; an answer in request cycle n completes cleanly iff n <= TO-1.
   task automatic model_push(input bit cb, input cmd_t c);
      exp_t e;
      logic [DATA_W-1:0] rd;
      e.client_b = cb;
      e.we       = c.we;
      e.addr     = c.addr;
      e.wdata    = c.wdata;
      e.n        = c.n;
      e.err      = (c.n > TO - 1);
      if (!e.err) begin
         if (c.we) ref_mem[c.addr] = c.wdata;
         else begin
            rd = ref_mem.exists(c.addr) ? ref_mem[c.addr] : '0;
            if (cb) m_rd_b = rd; else m_rd_a = rd;
         end
      end else begin
         m_sticky = 1'b1;
      end
      e.rd_a = m_rd_a;
      e.rd_b = m_rd_b;
      e.oerr = m_sticky;
      exp_q.push_back(e);
   endtask

   task automatic drive_a(input cmd_t c);
      ia_we = c.we; ia_address = c.addr; ia_wdata = c.wdata; ia_req = 1'b1;
   endtask

   task automatic drive_b(input cmd_t c);
      ib_we = c.we; ib_address = c.addr; ib_wdata = c.wdata; ib_req = 1'b1;
   endtask

   // Clients A and B issue na/nb commands back to back; predicted order follows round-robin rules.
   task automatic run_round(input int na, input int nb);
      int ia, ib, cyc;
      bit take_b;
      ia = 0; ib = 0;
      while (ia < na || ib < nb) begin
         if (ia < na && ib < nb) take_b = !m_last_b;
         else                    take_b = (ib < nb);
         if (take_b) begin model_push(1'b1, cmd_b[ib]); ib++; end
         else        begin model_push(1'b0, cmd_a[ia]); ia++; end
         m_last_b = take_b;
      end
      ia = 0; ib = 0;
      if (na > 0) drive_a(cmd_a[0]);
      if (nb > 0) drive_b(cmd_b[0]);
      cyc = 0;
      while ((ia < na || ib < nb) && cyc < 400) begin
         @(negedge iclk);
         cyc++;
         if (oa_ack && ia < na) begin
            ia++;
            if (ia < na) drive_a(cmd_a[ia]);
            else begin
               ia_req = 1'b0; ia_we = 1'($urandom_range(0, 1));
               ia_address = ADDR_W'($urandom); ia_wdata = DATA_W'($urandom);
            end
         end
         if (ob_ack && ib < nb) begin
            ib++;
            if (ib < nb) drive_b(cmd_b[ib]);
            else begin
               ib_req = 1'b0; ib_we = 1'($urandom_range(0, 1));
               ib_address = ADDR_W'($urandom); ib_wdata = DATA_W'($urandom);
            end
         end
      end
      check("round_completed", 128'((ia < na) || (ib < nb)), 128'(0));
   endtask

   // Controller model: answers in the planned request cycle, sprinkles wrong-port and idle acks.
   exp_t cur;
   bit   active = 1'b0;
   bit   acked  = 1'b0;
   int   hi_cnt = 0;
   always @(negedge iclk) begin
      iwrite_ack = 1'b0;
      iread_ack  = 1'b0;
      iread_data = DATA_W'($urandom);
      if (!ireset_n) begin
         active = 1'b0;
      end else if (owrite_req || oread_req) begin
         check("ctrl_one_request", 128'(owrite_req & oread_req), 128'(0));
         if (!active) begin
            active = 1'b1;
            acked  = 1'b0;
            hi_cnt = 0;
            check("ctrl_request_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) cur = exp_q[0];
         end
         hi_cnt++;
         check("ctrl_req_kind", 128'(owrite_req), 128'(cur.we));
         if (cur.we) begin
            check("ctrl_write_addr", 128'(owrite_address), 128'(cur.addr));
            check("ctrl_write_data", 128'(owrite_data), 128'(cur.wdata));
         end else begin
            check("ctrl_read_addr", 128'(oread_address), 128'(cur.addr));
         end
         if (!acked && hi_cnt == cur.n) begin
            acked = 1'b1;
            if (cur.we) begin
               iwrite_ack = 1'b1;
               ctrl_mem[cur.addr] = owrite_data;
            end else begin
               iread_ack  = 1'b1;
               iread_data = ctrl_mem.exists(cur.addr) ? ctrl_mem[cur.addr] : '0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            if (cur.we) iread_ack  = 1'b1;
            else        iwrite_ack = 1'b1;
         end
      end else begin
         if (active) begin
            active = 1'b0;
            if (!acked) check("timeout_req_cycles", 128'(hi_cnt), 128'(TO - 1));
         end
         if (idle_spur_en) begin
            iwrite_ack = 1'($urandom_range(0, 1));
            iread_ack  = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: every client ack retires the oldest expectation.
   exp_t me;
   bit   prev_ack = 1'b0;
   always @(negedge iclk) begin
      if (!ireset_n) begin
         prev_ack = 1'b0;
      end else begin
         if (oa_ack || ob_ack || oa_err || ob_err) begin
            check("ack_exclusive", 128'(oa_ack & ob_ack), 128'(0));
            check("ack_single_cycle", 128'(prev_ack), 128'(0));
            check("ack_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
               me = exp_q.pop_front();
               check("ack_a", 128'(oa_ack), 128'(!me.client_b));
               check("ack_b", 128'(ob_ack), 128'(me.client_b));
               check("err_a", 128'(oa_err), 128'(!me.client_b && me.err));
               check("err_b", 128'(ob_err), 128'(me.client_b && me.err));
               check("rdata_a", 128'(oa_rdata), 128'(me.rd_a));
               check("rdata_b", 128'(ob_rdata), 128'(me.rd_b));
               check("oerror_sticky", 128'(oerror), 128'(me.oerr));
            end
         end
         prev_ack = oa_ack | ob_ack;
      end
   end

   initial begin
      int na, nb, cyc;
      cmd_t c;
      ireset_n = 1'b0;
      ia_req = 1'b0; ia_we = 1'b0; ia_address = '0; ia_wdata = '0;
      ib_req = 1'b0; ib_we = 1'b0; ib_address = '0; ib_wdata = '0;
      model_reset();
      #1 check("reset_outputs", outs_all, 128'(0));
      repeat (3) @(negedge iclk);
      ireset_n = 1'b1;
      @(negedge iclk);

      // tie right after reset: A first, then strict alternation while both keep requesting
      gen_random();
      cmd_a[0].n = 2; cmd_b[0].n = 3; cmd_a[1].n = 1; cmd_b[1].n = 4;
      run_round(2, 2);

      // single write then read-back on A
      cmd_a[0] = '{we: 1'b1, addr: 22'h000003, wdata: 16'h0016, n: 5};
      run_round(1, 0);
      cmd_a[0] = '{we: 1'b0, addr: 22'h000003, wdata: 16'h0000, n: 3};
      run_round(1, 0);

      // B times out, then an answered command on A completes without err
      gen_random();
      cmd_b[0].n = TO + 4;
      run_round(0, 1);
      cmd_a[0] = '{we: 1'b1, addr: 22'h155555, wdata: 16'hBEEF, n: 2};
      run_round(1, 0);

      // ack landing on the timeout edge wins
      cmd_a[0] = '{we: 1'b0, addr: 22'h155555, wdata: 16'h0000, n: TO - 1};
      run_round(1, 0);

      for (int r = 0; r < 150; r++) begin
         na = int'($urandom_range(0, 2));
         nb = int'($urandom_range(0, 2));
         if (na == 0 && nb == 0) na = 1;
         gen_random();
         run_round(na, nb);
         idle_spur_en = 1'b1;
         repeat ($urandom_range(0, 4)) @(negedge iclk);
         idle_spur_en = 1'b0;
      end

      // reset in the middle of ISSUE: no ack for the aborted command
      c = '{we: 1'b1, addr: 22'h0A0A0A, wdata: 16'h5A5A, n: TO + 10};
      model_push(1'b0, c);
      drive_a(c);
      cyc = 0;
      while (!owrite_req && cyc < 20) begin
         @(negedge iclk);
         cyc++;
      end
      check("reset_test_req_seen", 128'(owrite_req), 128'(1));
      @(negedge iclk);
      #2 ireset_n = 1'b0;
      #1 check("reset_mid_issue_outputs", outs_all, 128'(0));
      ia_req = 1'b0;
      exp_q.delete();
      model_reset();
      repeat (3) @(negedge iclk);
      ireset_n = 1'b1;
      repeat (3) @(negedge iclk);

      // first tie after reset goes to A again
      gen_random();
      cmd_a[0].n = 1; cmd_b[0].n = 2;
      run_round(1, 1);

      repeat (4) @(negedge iclk);
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
